// File: rtl/gray_counter.sv
// Registered binary counter with a flopped Gray-code copy and a one-cycle wrap pulse.
// Define GRAY_CNT_DOWN_EN to enable down counting via dn; otherwise the counter is up-only.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             en,
  input  logic             dn,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nxt_bin;
  logic             nxt_wrap;

`ifndef GRAY_CNT_DOWN_EN
  logic dn_unused;
  assign dn_unused = dn;
`endif

  always_comb begin
    nxt_bin  = bin;
    nxt_wrap = 1'b0;
    if (clr) begin
      nxt_bin = '0;
    end else if (load) begin
      nxt_bin = load_bin;
    end else if (en) begin
`ifdef GRAY_CNT_DOWN_EN
      if (dn) begin
        nxt_bin  = bin - ONE;
        nxt_wrap = (bin == '0);
      end else begin
        nxt_bin  = bin + ONE;
        nxt_wrap = &bin;
      end
`else
      nxt_bin  = bin + ONE;
      nxt_wrap = &bin;
`endif
    end
  end

  // Gray is encoded from the next binary value so both registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= nxt_bin;
      gray <= nxt_bin ^ (nxt_bin >> 1);
      wrap <= nxt_wrap;
    end
  end

endmodule
